sipo_shift_register: RTL and testbench

- Serial-in parallel-out deserializer: the receive end of the team's 4-bit PISO shift register link.
- Samples one serial bit per qualified clock, assembles WIDTH bits into a word, and presents the word on a valid/ready parallel interface.
- A bit counter / two-state FSM tracks frame position.
- A sticky flag reports words lost because the consumer stalled.

---
 rtl/sipo_shift_register_if.sv | 56 +++++
 rtl/sipo_shift_register.sv | 143 ++++++++++++++
 tb/tb_sipo_shift_register.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sipo_shift_register_if.sv
// ---------------------------------------------------------------------------
// sipo_shift_register_if
// Signal bundle between the serial receiver (sipo_shift_register) and the
// logic around it.
//
//   din         serial data bit                         (master -> slave)
//   din_valid   din is sampled on this edge only when 1 (master -> slave)
//   clear       synchronous frame abort                 (master -> slave)
//   dout_ready  consumer accepts dout                   (master -> slave)
//   dout        assembled word (holding register)       (slave -> master)
//   dout_valid  holding register has an unconsumed word (slave -> master)
//   bit_count   bits collected in the partial word      (slave -> master)
//   busy        a frame is in progress                  (slave -> master)
//   overrun     sticky: a completed word was dropped    (slave -> master)
// ---------------------------------------------------------------------------
interface sipo_shift_register_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             din;
    logic             din_valid;
    logic             clear;
    logic             dout_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    bit_count;
    logic             busy;
    logic             overrun;

    // The receiver itself.
    modport slave (
        input  din,
        input  din_valid,
        input  clear,
        input  dout_ready,
        output dout,
        output dout_valid,
        output bit_count,
        output busy,
        output overrun
    );

    // The side that feeds serial bits and consumes words.
    modport master (
        output din,
        output din_valid,
        output clear,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  bit_count,
        input  busy,
        input  overrun
    );
endinterface

// File: rtl/sipo_shift_register.sv
// ---------------------------------------------------------------------------
// sipo_shift_register
// Serial-in parallel-out deserializer: samples one bit per din_valid cycle,
// assembles WIDTH bits into a word and offers it on a valid/ready holding
// register. A sticky overrun flag records words dropped because the
// holding register was still occupied when the next word completed.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: first received bit lands in dout[WIDTH-1]
//              0: first received bit lands in dout[0]
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    sipo_shift_register_if.slave (din/din_valid/clear/dout_ready in,
//          dout/dout_valid/bit_count/busy/overrun out)
// ---------------------------------------------------------------------------
module sipo_shift_register #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    sipo_shift_register_if.slave         bus
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state_reg,      w_state_next;
    logic [CW-1:0]    r_bit_count_reg,  w_bit_count_next;
    logic [WIDTH-1:0] r_shift_reg,      w_shift_next;
    logic [WIDTH-1:0] r_dout_reg,       w_dout_next;
    logic             r_dout_valid_reg, w_dout_valid_next;
    logic             r_overrun_reg,    w_overrun_next;

    logic [WIDTH-1:0] w_shifted;
    logic             w_sample;
    logic             w_last;

    // Shift direction fixed at elaboration time.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shift_reg[WIDTH-2:0], bus.din};
        end else begin : g_lsb_first
            assign w_shifted = {bus.din, r_shift_reg[WIDTH-1:1]};
        end
    endgenerate

    // clear wins over a simultaneous din_valid: that bit is discarded.
    assign w_sample = bus.din_valid && !bus.clear;
    // This sample carries the final bit of the word.
    assign w_last   = w_sample && (r_bit_count_reg == LAST);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_reg      <= ST_IDLE;
            r_bit_count_reg  <= '0;
            r_shift_reg      <= '0;
            r_dout_reg       <= '0;
            r_dout_valid_reg <= 1'b0;
            r_overrun_reg    <= 1'b0;
        end else begin
            r_state_reg      <= w_state_next;
            r_bit_count_reg  <= w_bit_count_next;
            r_shift_reg      <= w_shift_next;
            r_dout_reg       <= w_dout_next;
            r_dout_valid_reg <= w_dout_valid_next;
            r_overrun_reg    <= w_overrun_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state_reg;
        w_bit_count_next  = r_bit_count_reg;
        w_shift_next      = r_shift_reg;
        w_dout_next       = r_dout_reg;
        w_dout_valid_next = r_dout_valid_reg;
        w_overrun_next    = r_overrun_reg;

        // Frame position
        if (bus.clear) begin
            w_state_next     = ST_IDLE;
            w_bit_count_next = '0;
            w_shift_next     = '0;
            w_overrun_next   = 1'b0;
        end else if (bus.din_valid) begin
            w_shift_next = w_shifted;
            case (r_state_reg)
                ST_IDLE: begin
                    w_state_next     = ST_SHIFT;
                    w_bit_count_next = CW'(1);
                end
                ST_SHIFT: begin
                    if (r_bit_count_reg == LAST) begin
                        w_state_next     = ST_IDLE;
                        w_bit_count_next = '0;
                    end else begin
                        w_bit_count_next = r_bit_count_reg + CW'(1);
                    end
                end
                default: begin
                    w_state_next     = ST_IDLE;
                    w_bit_count_next = '0;
                end
            endcase
        end

        // Holding register: consumption first, then a completing word may
        // refill it on the same edge (valid then stays high).
        if (r_dout_valid_reg && bus.dout_ready) begin
            w_dout_valid_next = 1'b0;
        end
        if (w_last) begin
            if (!r_dout_valid_reg || bus.dout_ready) begin
                w_dout_next       = w_shifted;
                w_dout_valid_next = 1'b1;
            end else begin
                // Holding register still occupied: drop the new word.
                w_overrun_next = 1'b1;
            end
        end
    end

    assign bus.dout       = r_dout_reg;
    assign bus.dout_valid = r_dout_valid_reg;
    assign bus.bit_count  = r_bit_count_reg;
    assign bus.busy       = (r_state_reg == ST_SHIFT);
    assign bus.overrun    = r_overrun_reg;

endmodule

// File: tb/tb_sipo_shift_register.sv
// ---------------------------------------------------------------------------
// tb_sipo_shift_register
// Drives one serial stream into two receivers (MSB-first and LSB-first,
// WIDTH=4). A bit-list reference model predicts every output each cycle;
// words loaded into the holding register are queued and popped when the
// consumer handshake takes them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sipo_shift_register;

    localparam int W  = 4;
    localparam int CW = $clog2(W) + 1;

    logic clk;
    logic reset;

    sipo_shift_register_if #(.WIDTH(W)) bus_m ();
    sipo_shift_register_if #(.WIDTH(W)) bus_l ();

    sipo_shift_register #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_m.slave)
    );

    sipo_shift_register #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit          m_bits[$];
    logic [W-1:0] m_dout_m, m_dout_l;
    logic         m_valid;
    logic         m_overrun;
    logic [W-1:0] q_m[$];
    logic [W-1:0] q_l[$];

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".dout_m"},      32'(bus_m.dout),       32'(m_dout_m));
        chk({tag, ".dout_l"},      32'(bus_l.dout),       32'(m_dout_l));
        chk({tag, ".valid_m"},     32'(bus_m.dout_valid), 32'(m_valid));
        chk({tag, ".valid_l"},     32'(bus_l.dout_valid), 32'(m_valid));
        chk({tag, ".bit_count_m"}, 32'(bus_m.bit_count),  32'(m_bits.size()));
        chk({tag, ".bit_count_l"}, 32'(bus_l.bit_count),  32'(m_bits.size()));
        chk({tag, ".busy_m"},      32'(bus_m.busy),       32'(m_bits.size() != 0));
        chk({tag, ".busy_l"},      32'(bus_l.busy),       32'(m_bits.size() != 0));
        chk({tag, ".overrun_m"},   32'(bus_m.overrun),    32'(m_overrun));
        chk({tag, ".overrun_l"},   32'(bus_l.overrun),    32'(m_overrun));
    endtask

    task automatic drive(input logic b, input logic dv, input logic rdy, input logic clr);
        bus_m.din = b;  bus_m.din_valid = dv; bus_m.dout_ready = rdy; bus_m.clear = clr;
        bus_l.din = b;  bus_l.din_valid = dv; bus_l.dout_ready = rdy; bus_l.clear = clr;
    endtask

    // One clock cycle: drive at negedge, score the handshake before the
    // edge, advance the model, then compare #1 after the edge.
    task automatic step(input string tag, input logic b, input logic dv,
                        input logic rdy, input logic clr);
        logic         accepted;
        logic         loaded;
        logic [W-1:0] wm, wl;
        logic [W-1:0] em, el;
        @(negedge clk);
        reset = 1'b0;
        drive(b, dv, rdy, clr);
        accepted = m_valid && rdy;
        loaded   = 1'b0;
        if (accepted) begin
            chk({tag, ".sb_nonempty"}, 32'(q_m.size() > 0), 32'd1);
            if (q_m.size() > 0) begin
                em = q_m.pop_front();
                el = q_l.pop_front();
                chk({tag, ".accept_m"}, 32'(bus_m.dout), 32'(em));
                chk({tag, ".accept_l"}, 32'(bus_l.dout), 32'(el));
            end
        end
        if (clr) begin
            m_bits.delete();
            m_overrun = 1'b0;
        end else if (dv) begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = m_bits[i];
                    wl[i]     = m_bits[i];
                end
                m_bits.delete();
                if (!m_valid || rdy) begin
                    m_dout_m = wm;
                    m_dout_l = wl;
                    loaded   = 1'b1;
                    q_m.push_back(wm);
                    q_l.push_back(wl);
                end else begin
                    m_overrun = 1'b1;
                end
            end
        end
        if (loaded)        m_valid = 1'b1;
        else if (accepted) m_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        m_bits.delete();
        q_m.delete();
        q_l.delete();
        m_dout_m  = '0;
        m_dout_l  = '0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic send_word(input string tag, input logic [W-1:0] w, input logic rdy);
        for (int i = W - 1; i >= 0; i--) begin
            step(tag, w[i], 1'b1, rdy, 1'b0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        m_dout_m  = '0;
        m_dout_l  = '0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;

        // Reset state
        do_reset("reset");

        // MSB-first word 1,0,1,1 with consumer ready
        send_word("msb1011", 4'b1011, 1'b1);
        chk("msb1011.word", 32'(bus_m.dout), 32'hB);
        step("msb1011.drain", 1'b0, 1'b0, 1'b1, 1'b0);

        // Serial patterns that read 0001 / 0110 on the LSB-first receiver
        send_word("seq1000", 4'b1000, 1'b1);
        chk("lsb0001.word", 32'(bus_l.dout), 32'h1);
        send_word("seq0110", 4'b0110, 1'b1);
        chk("lsb0110.word", 32'(bus_l.dout), 32'h6);
        step("seq.drain", 1'b0, 1'b0, 1'b1, 1'b0);

        // Gapped input: three idle cycles between bits
        for (int i = 3; i >= 0; i--) begin
            logic [W-1:0] g;
            g = 4'b1101;
            step("gap.bit", g[i], 1'b1, 1'b1, 1'b0);
            if (i != 0) begin
                for (int k = 0; k < 3; k++) step("gap.idle", 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end
        step("gap.drain", 1'b0, 1'b0, 1'b1, 1'b0);
        step("gap.empty", 1'b0, 1'b0, 1'b1, 1'b0);

        // Stall: second word dropped, overrun sticky until clear
        send_word("stall1010", 4'b1010, 1'b0);
        send_word("stall0101", 4'b0101, 1'b0);
        chk("stall.dout", 32'(bus_m.dout), 32'hA);
        chk("stall.overrun", 32'(bus_m.overrun), 32'd1);
        step("stall.accept", 1'b0, 1'b0, 1'b1, 1'b0);
        step("stall.hold", 1'b0, 1'b0, 1'b1, 1'b0);
        step("stall.clear", 1'b0, 1'b0, 1'b1, 1'b1);

        // Simultaneous accept and complete
        send_word("pend0011", 4'b0011, 1'b0);
        step("sim.b3", 1'b1, 1'b1, 1'b0, 1'b0);
        step("sim.b2", 1'b1, 1'b1, 1'b0, 1'b0);
        step("sim.b1", 1'b0, 1'b1, 1'b0, 1'b0);
        step("sim.b0", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sim.dout", 32'(bus_m.dout), 32'hC);
        step("sim.drain", 1'b0, 1'b0, 1'b1, 1'b0);

        // Abort with clear mid-frame (bit on the clear cycle is ignored)
        step("clr.b0", 1'b1, 1'b1, 1'b1, 1'b0);
        step("clr.b1", 1'b0, 1'b1, 1'b1, 1'b0);
        step("clr.pulse", 1'b1, 1'b1, 1'b1, 1'b1);
        send_word("clr1110", 4'b1110, 1'b1);
        chk("clr.dout", 32'(bus_m.dout), 32'hE);

        // Reset mid-frame with a pending word
        step("rst.b0", 1'b1, 1'b1, 1'b0, 1'b0);
        step("rst.b1", 1'b0, 1'b1, 1'b0, 1'b0);
        do_reset("rst.mid");
        send_word("post1001", 4'b1001, 1'b1);
        step("post.drain", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
